hilo_ctrl: RTL and testbench
============================

# hilo_ctrl

Multi-cycle sequencer and HI/LO register owner for the multiply/divide path of the multicycle CPU. Accepts a start request from the control unit, holds DivCtrl or MultCtrl high for a fixed cycle budget, and captures the selected unit's HI/LO outputs into the architectural HI/LO registers. Also raises a divide-by-zero exception, serves mthi/mtlo writes, and stalls mfhi/mflo while an operation is in flight.

## Interface
- DIV_CYCLES, 34: number of cycles DivCtrl is held high per divide.
- MULT_CYCLES, 33: number of cycles MultCtrl is held high per multiply.
- CNT_W, 6: counter width; must satisfy 2^CNT_W > max(DIV_CYCLES, MULT_CYCLES).
- Clock  in  1  rising-edge clock.
- Reset  in  1  reset, synchronous, active-high.
- Start  in  1  start request; sampled only in IDLE.
- OpDiv  in  1  1 = divide, 0 = multiply; sampled with Start.
- DivisorIn  in  32  divisor operand (B register); used only by the precheck option.
- DivHI, DivLO  in  32 each  divider results.
- Div0  in  1  divider's zero-divisor flag.
- MultHI, MultLO  in  32 each  multiplier results.
- MtHi, MtLo  in  1 each  write WrData into HI / LO.
- WrData  in  32  mthi/mtlo data.
- MfReq  in  1  mfhi/mflo read request.
- DivCtrl, MultCtrl  out  1 each  operation enables to the units.
- HI, LO  out  32 each  architectural registers.
- Busy  out  1  operation in flight.
- Done  out  1  one-cycle pulse when HI/LO have been loaded from a unit.
- DivZeroExc  out  1  one-cycle divide-by-zero exception pulse.
- Stall  out  1  combinational: (MfReq | MtHi | MtLo) & Busy.

## Operation
- State machine: IDLE, RUN, DONE, EXC. Op latch holds OpDiv; counter is CNT_W bits.
- Reset:
  - State goes to IDLE.
  - HI=0, LO=0, counter=0.
  - DivCtrl, MultCtrl, Busy, Done and DivZeroExc all go to 0.
  - This applies in any state, including mid-operation; the unit enable drops on the next cycle.
- IDLE, Start=1:
  - Latch OpDiv, clear the counter, go to RUN.
  - Start is ignored in every other state.
- RUN:
  - DivCtrl = op latch; MultCtrl = !op latch; Busy = 1.
  - The counter increments each cycle.
  - When the counter equals N-1 (N = DIV_CYCLES or MULT_CYCLES): load HI/LO from the selected unit, go to DONE.
  - For a divide: HI <= DivHI, LO <= DivLO. For a multiply: HI <= MultHI, LO <= MultLO.
- RUN, op = divide, Div0 = 1:
  - Go to EXC immediately; HI/LO are left unchanged.
  - Div0 takes priority over the terminal count.
- DONE: Done = 1, Busy = 0, all unit enables low; go to IDLE. This gives a guaranteed one-cycle enable gap between back-to-back ops.
- EXC: DivZeroExc = 1, Done = 0, Busy = 0; go to IDLE.
- MtHi/MtLo:
  - Applied only when Busy = 0, at the clock edge.
  - When Busy = 1 the write is ignored and Stall = 1; the control unit retries.
  - MtHi and MtLo together: both registers are written.
- Simultaneous MtHi/MtLo and Start in IDLE: the write is applied and Start is accepted; the later result overwrites.
- MfReq: HI/LO are always readable; Stall is asserted only while Busy.

## Timing
- Start sampled at edge E0. Busy/enable high from E0 through the cycle before edge E0+N. HI/LO load at edge E0+N. Done high for the cycle after E0+N. Start is accepted again from edge E0+N+1.
- Divide latency at defaults: 34 cycles of DivCtrl; Done visible in cycle 35 after the Start edge.
- Div0 seen high in RUN cycle k: DivZeroExc is high in cycle k+1 and the enable is low from cycle k+1.
- Done and DivZeroExc are never high together and are never high for more than one cycle.

## Configuration
- HILO_DIV0_PRECHECK_EN defined:
  - IDLE, Start=1, OpDiv=1, DivisorIn=0: go directly to EXC. DivCtrl is never asserted; DivZeroExc is high in the cycle after the Start edge.
- HILO_DIV0_PRECHECK_EN undefined:
  - Zero divisors are detected only via Div0 during RUN.
  - The Div0 path in RUN is present in both builds.

## Test plan
- Reset, then divide: Start with OpDiv=1, DivHI=0x3, DivLO=0x1 held → DivCtrl high exactly 34 cycles; HI=0x3, LO=0x1; Done is a single pulse 35 cycles after Start; MultCtrl stays 0.
- Multiply: OpDiv=0, MultHI=0x1, MultLO=0xFFFFFFFE → MultCtrl high 33 cycles; HI=0x1, LO=0xFFFFFFFE; Done pulses once.
- Div0 raised in RUN cycle 5 → DivZeroExc pulses in cycle 6; HI/LO keep their prior values (e.g. 0xAAAA/0x5555 from mthi/mtlo); no Done. With HILO_DIV0_PRECHECK_EN and DivisorIn=0 → DivZeroExc one cycle after Start; DivCtrl never rises.
- MtHi with WrData=0x1234 during RUN → Stall=1 and HI unchanged. Retry after Done → HI=0x1234. MfReq during RUN → Stall=1; MfReq in IDLE → Stall=0.
- Reset asserted in RUN cycle 10 → next cycle: IDLE, HI=LO=0, DivCtrl=0, no Done.
- Back-to-back: Start held continuously → enable low for exactly one cycle (DONE) between ops; the second op is accepted at the edge after DONE.

Source files
------------

// File: rtl/hilo_ctrl.sv
// Multiply/divide sequencer that owns the architectural HI/LO registers.
// Optional build macro HILO_DIV0_PRECHECK_EN rejects a zero divisor before the divider is started.
module hilo_ctrl #(
  parameter int DIV_CYCLES  = 34,
  parameter int MULT_CYCLES = 33,
  parameter int CNT_W       = 6
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic        OpDiv,
  input  logic [31:0] DivisorIn,
  input  logic [31:0] DivHI,
  input  logic [31:0] DivLO,
  input  logic        Div0,
  input  logic [31:0] MultHI,
  input  logic [31:0] MultLO,
  input  logic        MtHi,
  input  logic        MtLo,
  input  logic [31:0] WrData,
  input  logic        MfReq,
  output logic        DivCtrl,
  output logic        MultCtrl,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy,
  output logic        Done,
  output logic        DivZeroExc,
  output logic        Stall
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, EXC} state_t;

`ifdef HILO_DIV0_PRECHECK_EN
  localparam bit PRECHECK_EN = 1'b1;
`else
  localparam bit PRECHECK_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);

  state_t           state_reg;
  logic             op_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] last_cnt;
  logic             precheck_hit;

  assign last_cnt     = op_reg ? DIV_LAST : MULT_LAST;
  assign precheck_hit = PRECHECK_EN & OpDiv & (DivisorIn == 32'd0);
  assign Stall        = (MfReq | MtHi | MtLo) & Busy;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg  <= IDLE;
      op_reg     <= 1'b0;
      cnt_reg    <= '0;
      HI         <= 32'd0;
      LO         <= 32'd0;
      DivCtrl    <= 1'b0;
      MultCtrl   <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      DivZeroExc <= 1'b0;
    end else begin
      DivCtrl    <= 1'b0;
      MultCtrl   <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      DivZeroExc <= 1'b0;

      // Moves to HI/LO only land while no operation owns the registers.
      if (!Busy) begin
        if (MtHi) HI <= WrData;
        if (MtLo) LO <= WrData;
      end

      case (state_reg)
        // Leaving DONE doubles as the idle sampling point so a held Start
        // sees exactly one dead cycle between operations.
        IDLE, DONE: begin
          state_reg <= IDLE;
          if (Start) begin
            if (precheck_hit) begin
              state_reg  <= EXC;
              DivZeroExc <= 1'b1;
            end else begin
              state_reg <= RUN;
              op_reg    <= OpDiv;
              cnt_reg   <= '0;
              DivCtrl   <= OpDiv;
              MultCtrl  <= ~OpDiv;
              Busy      <= 1'b1;
            end
          end
        end

        RUN: begin
          if (op_reg && Div0) begin
            state_reg  <= EXC;
            DivZeroExc <= 1'b1;
          end else if (cnt_reg == last_cnt) begin
            HI        <= op_reg ? DivHI : MultHI;
            LO        <= op_reg ? DivLO : MultLO;
            state_reg <= DONE;
            Done      <= 1'b1;
          end else begin
            cnt_reg  <= cnt_reg + 1'b1;
            DivCtrl  <= op_reg;
            MultCtrl <= ~op_reg;
            Busy     <= 1'b1;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl: table of whole operations plus hand sequences
// for stalls, reset mid-operation, simultaneous move/start and back-to-back starts.
module tb_hilo_ctrl;

  logic        Clock = 1'b0;
  logic        Reset, Start, OpDiv, Div0, MtHi, MtLo, MfReq;
  logic [31:0] DivisorIn, DivHI, DivLO, MultHI, MultLO, WrData;
  logic        DivCtrl, MultCtrl, Busy, Done, DivZeroExc, Stall;
  logic [31:0] HI, LO;

  int errors = 0;
  int checks = 0;

  always #5 Clock = ~Clock;

  hilo_ctrl dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .OpDiv(OpDiv),
    .DivisorIn(DivisorIn), .DivHI(DivHI), .DivLO(DivLO), .Div0(Div0),
    .MultHI(MultHI), .MultLO(MultLO), .MtHi(MtHi), .MtLo(MtLo),
    .WrData(WrData), .MfReq(MfReq), .DivCtrl(DivCtrl), .MultCtrl(MultCtrl),
    .HI(HI), .LO(LO), .Busy(Busy), .Done(Done), .DivZeroExc(DivZeroExc),
    .Stall(Stall)
  );

  typedef struct {
    bit          op_div;
    logic [31:0] divisor;
    logic [31:0] hi_in;
    logic [31:0] lo_in;
    int          div0_at;
    bit          pre_wr;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    int          exp_div;
    int          exp_mult;
    int          exp_done;
    int          exp_done_at;
    int          exp_exc;
    int          exp_exc_at;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clock);
      if (Done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic run_op(input int idx, input vec_t v);
    int div_cnt = 0, mult_cnt = 0, done_cnt = 0, exc_cnt = 0, both = 0;
    int done_at = -1, exc_at = -1;
    if (v.pre_wr) begin
      MtHi = 1'b1; WrData = v.pre_hi;
      step();
      MtHi = 1'b0; MtLo = 1'b1; WrData = v.pre_lo;
      step();
      MtLo = 1'b0;
      chk("pre_hi", HI, v.pre_hi);
      chk("pre_lo", LO, v.pre_lo);
    end
    OpDiv = v.op_div; DivisorIn = v.divisor;
    DivHI  = v.op_div ? v.hi_in : ~v.hi_in;
    DivLO  = v.op_div ? v.lo_in : ~v.lo_in;
    MultHI = v.op_div ? ~v.hi_in : v.hi_in;
    MultLO = v.op_div ? ~v.lo_in : v.lo_in;
    Start = 1'b1;
    step();
    Start = 1'b0;
    for (int j = 0; j < 50; j++) begin
      Div0 = (j == v.div0_at);
      @(negedge Clock);
      if (DivCtrl) div_cnt++;
      if (MultCtrl) mult_cnt++;
      if (Done) begin done_cnt++; done_at = j; end
      if (DivZeroExc) begin exc_cnt++; exc_at = j; end
      if (Done && DivZeroExc) both++;
      step();
    end
    Div0 = 1'b0;
    $display("op %0d: div_cycles=%0d mult_cycles=%0d done=%0d@%0d exc=%0d@%0d HI=%08h LO=%08h",
             idx, div_cnt, mult_cnt, done_cnt, done_at, exc_cnt, exc_at, HI, LO);
    chk("div_cycles", div_cnt, v.exp_div);
    chk("mult_cycles", mult_cnt, v.exp_mult);
    chk("done_count", done_cnt, v.exp_done);
    chk("done_at", done_at, v.exp_done_at);
    chk("exc_count", exc_cnt, v.exp_exc);
    chk("exc_at", exc_at, v.exp_exc_at);
    chk("done_and_exc", both, 0);
    chk("hi", HI, v.exp_hi);
    chk("lo", LO, v.exp_lo);
  endtask

  initial begin
    // op, divisor, hi_in, lo_in, div0_at, pre_wr, pre_hi, pre_lo,
    // exp div/mult cycles, done count/at, exc count/at, exp HI/LO
    tbl[0] = '{1, 32'd7, 32'h3, 32'h1, -1, 0, 0, 0, 34, 0, 1, 34, 0, -1, 32'h3, 32'h1};
    tbl[1] = '{0, 32'd7, 32'h1, 32'hFFFFFFFE, -1, 0, 0, 0, 0, 33, 1, 33, 0, -1, 32'h1, 32'hFFFFFFFE};
    tbl[2] = '{1, 32'd7, 32'hDEAD, 32'hBEEF, 5, 1, 32'hAAAA, 32'h5555, 6, 0, 0, -1, 1, 6, 32'hAAAA, 32'h5555};
    tbl[3] = '{1, 32'd3, 32'h12345678, 32'h9ABCDEF0, -1, 0, 0, 0, 34, 0, 1, 34, 0, -1, 32'h12345678, 32'h9ABCDEF0};
    // Div0 on the terminal-count cycle must still win
    tbl[4] = '{1, 32'd3, 32'h1111, 32'h2222, 33, 0, 0, 0, 34, 0, 0, -1, 1, 34, 32'h12345678, 32'h9ABCDEF0};
    // Div0 is irrelevant to a multiply
    tbl[5] = '{0, 32'd3, 32'h0F0F0F0F, 32'hF0F0F0F0, 3, 0, 0, 0, 0, 33, 1, 33, 0, -1, 32'h0F0F0F0F, 32'hF0F0F0F0};
`ifdef HILO_DIV0_PRECHECK_EN
    tbl[6] = '{1, 32'd0, 32'h11, 32'h22, -1, 0, 0, 0, 0, 0, 0, -1, 1, 0, 32'h0F0F0F0F, 32'hF0F0F0F0};
`else
    tbl[6] = '{1, 32'd0, 32'h11, 32'h22, -1, 0, 0, 0, 34, 0, 1, 34, 0, -1, 32'h11, 32'h22};
`endif

    Reset = 1'b1; Start = 1'b0; OpDiv = 1'b0; Div0 = 1'b0; MtHi = 1'b0; MtLo = 1'b0;
    MfReq = 1'b1; DivisorIn = 32'd7; DivHI = '0; DivLO = '0; MultHI = '0; MultLO = '0;
    WrData = 32'hFFFF_FFFF;
    step(); step();
    Reset = 1'b0;
    @(negedge Clock);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_ctrl", {30'd0, DivCtrl, MultCtrl}, 32'd0);
    chk("rst_flags", {29'd0, Busy, Done, DivZeroExc}, 32'd0);
    chk("idle_mfreq_stall", {31'd0, Stall}, 32'd0);
    MfReq = 1'b0;
    step();

    for (int i = 0; i < 7; i++) run_op(i, tbl[i]);

    // Move and read requests while a divide is running
    OpDiv = 1'b1; DivisorIn = 32'd5; DivHI = 32'h55; DivLO = 32'h66; Start = 1'b1;
    step();
    Start = 1'b0;
    step(); step(); step();
    MtHi = 1'b1; WrData = 32'h1234; MfReq = 1'b1;
    @(negedge Clock);
    chk("run_stall", {31'd0, Stall}, 32'd1);
    chk("run_busy", {31'd0, Busy}, 32'd1);
    step();
    MtHi = 1'b0; MfReq = 1'b0;
    chk("run_mthi_ignored", HI, tbl[6].exp_hi);
    wait_done("stall_done_seen");
    step();
    MtHi = 1'b1; WrData = 32'h1234; MfReq = 1'b1;
    @(negedge Clock);
    chk("idle_stall", {31'd0, Stall}, 32'd0);
    step();
    MtHi = 1'b0; MfReq = 1'b0;
    chk("retry_hi", HI, 32'h1234);
    chk("retry_lo_kept", LO, 32'h66);
    MtHi = 1'b1; MtLo = 1'b1; WrData = 32'hCAFE;
    step();
    MtHi = 1'b0; MtLo = 1'b0;
    chk("both_hi", HI, 32'hCAFE);
    chk("both_lo", LO, 32'hCAFE);
    $display("seq stall: HI=%08h LO=%08h", HI, LO);

    // Move and start on the same edge: move lands, result later overwrites
    MtHi = 1'b1; WrData = 32'h77; Start = 1'b1; OpDiv = 1'b0; MultHI = 32'h99; MultLO = 32'h98;
    step();
    MtHi = 1'b0; Start = 1'b0;
    @(negedge Clock);
    chk("simul_write_hi", HI, 32'h77);
    chk("simul_busy", {31'd0, Busy}, 32'd1);
    wait_done("simul_done_seen");
    chk("simul_result_hi", HI, 32'h99);
    chk("simul_result_lo", LO, 32'h98);
    step();
    $display("seq simultaneous: HI=%08h LO=%08h", HI, LO);

    // Reset in the middle of a divide
    OpDiv = 1'b1; DivHI = 32'hABC; DivLO = 32'hDEF; Start = 1'b1;
    step();
    Start = 1'b0;
    for (int j = 0; j < 10; j++) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    @(negedge Clock);
    chk("midrst_hi", HI, 32'd0);
    chk("midrst_lo", LO, 32'd0);
    chk("midrst_ctrl", {30'd0, DivCtrl, MultCtrl}, 32'd0);
    chk("midrst_flags", {29'd0, Busy, Done, DivZeroExc}, 32'd0);
    begin
      int late = 0;
      for (int j = 0; j < 40; j++) begin
        step();
        @(negedge Clock);
        if (Done || DivCtrl) late++;
      end
      chk("midrst_no_done", late, 0);
      $display("seq reset mid-run: late_activity=%0d", late);
    end
    step();

    // Start held through two multiplies
    begin
      int mc = 0, dn = 0, first_done = -1;
      logic gap = 1'b1, resume = 1'b0;
      OpDiv = 1'b0; MultHI = 32'h4; MultLO = 32'h5; Start = 1'b1;
      step();
      for (int j = 0; j < 70; j++) begin
        if (j == 40) Start = 1'b0;
        @(negedge Clock);
        if (MultCtrl) mc++;
        if (Done) begin
          dn++;
          if (first_done < 0) first_done = j;
        end
        if (j == 33) gap = MultCtrl;
        if (j == 34) resume = MultCtrl;
        step();
      end
      chk("b2b_mult_cycles", mc, 66);
      chk("b2b_done_count", dn, 2);
      chk("b2b_first_done", first_done, 33);
      chk("b2b_gap_low", {31'd0, gap}, 32'd0);
      chk("b2b_resume_high", {31'd0, resume}, 32'd1);
      $display("seq back-to-back: mult_cycles=%0d dones=%0d first_done=%0d", mc, dn, first_done);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
